// File: rtl/rpsc_ps_sequencer_if.sv
// Signal bundle between the RPSC supply sequencer and the standby/HV interlock card.
interface rpsc_ps_sequencer_if;
   logic       i17_PS_ON;
   logic       i_HV_REQ;
   logic       i73_Not_AN_HV_Ready;
   logic       i75_Not_RF_PERM;
   logic       i_FAULT_CLR;
   logic       o4_Not_FAN_ON;
   logic       o5_Not_G1_ON;
   logic       o6_Not_CA_ON;
   logic       o18_Not_G2_ON;
   logic       o19_Not_Anode_ON;
   logic       o3_Not_DR_AMP_ON;
   logic       o_FAULT;
   logic [3:0] o_STATE;

   modport slave (
      input  i17_PS_ON,
      input  i_HV_REQ,
      input  i73_Not_AN_HV_Ready,
      input  i75_Not_RF_PERM,
      input  i_FAULT_CLR,
      output o4_Not_FAN_ON,
      output o5_Not_G1_ON,
      output o6_Not_CA_ON,
      output o18_Not_G2_ON,
      output o19_Not_Anode_ON,
      output o3_Not_DR_AMP_ON,
      output o_FAULT,
      output o_STATE
   );

   modport master (
      output i17_PS_ON,
      output i_HV_REQ,
      output i73_Not_AN_HV_Ready,
      output i75_Not_RF_PERM,
      output i_FAULT_CLR,
      input  o4_Not_FAN_ON,
      input  o5_Not_G1_ON,
      input  o6_Not_CA_ON,
      input  o18_Not_G2_ON,
      input  o19_Not_Anode_ON,
      input  o3_Not_DR_AMP_ON,
      input  o_FAULT,
      input  o_STATE
   );
endinterface

// File: rtl/rpsc_ps_sequencer.sv
// Timed power-up/power-down sequencer for the RPSC tube supplies.
module rpsc_ps_sequencer #(
   parameter int unsigned FAN_DLY    = 8,
   parameter int unsigned G1_DLY     = 4,
   parameter int unsigned CA_DLY     = 16,
   parameter int unsigned G2_DLY     = 4,
   parameter int unsigned HV_TIMEOUT = 32,
   parameter int unsigned CNT_W      = 16
) (
   input logic clk,
   input logic reset,
   rpsc_ps_sequencer_if.slave bus
);

   typedef enum logic [3:0] {
      S_OFF     = 4'd0,
      S_FAN_UP  = 4'd1,
      S_G1_UP   = 4'd2,
      S_CA_WARM = 4'd3,
      S_STANDBY = 4'd4,
      S_G2_UP   = 4'd5,
      S_AN_WAIT = 4'd6,
      S_HV_ON   = 4'd7,
      S_COOL    = 4'd8,
      S_FAULT   = 4'd9
   } state_e;

   localparam logic [CNT_W-1:0] FAN_LAST = CNT_W'(FAN_DLY - 1);
   localparam logic [CNT_W-1:0] G1_LAST  = CNT_W'(G1_DLY - 1);
   localparam logic [CNT_W-1:0] CA_LAST  = CNT_W'(CA_DLY - 1);
   localparam logic [CNT_W-1:0] G2_LAST  = CNT_W'(G2_DLY - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(HV_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fan_n_q, fan_n_d;
   logic             g1_n_q, g1_n_d;
   logic             ca_n_q, ca_n_d;
   logic             g2_n_q, g2_n_d;
   logic             an_n_q, an_n_d;
   logic             dr_n_q, dr_n_d;
   logic             fault_q, fault_d;

   logic ps_on, hv_req, hv_rdy, rf_ok, clr;

   assign ps_on  = bus.i17_PS_ON;
   assign hv_req = bus.i_HV_REQ;
   assign hv_rdy = ~bus.i73_Not_AN_HV_Ready;
   assign rf_ok  = ~bus.i75_Not_RF_PERM;
   assign clr    = bus.i_FAULT_CLR;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         fan_n_q <= 1'b1;
         g1_n_q  <= 1'b1;
         ca_n_q  <= 1'b1;
         g2_n_q  <= 1'b1;
         an_n_q  <= 1'b1;
         dr_n_q  <= 1'b1;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fan_n_q <= fan_n_d;
         g1_n_q  <= g1_n_d;
         ca_n_q  <= ca_n_d;
         g2_n_q  <= g2_n_d;
         an_n_q  <= an_n_d;
         dr_n_q  <= dr_n_d;
         fault_q <= fault_d;
      end
   end

   // Priority inside each state: fault, PS_ON drop, HV_REQ drop, advance.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_OFF: begin
            if (ps_on) state_d = S_FAN_UP;
         end
         S_FAN_UP: begin
            if (!ps_on)                state_d = S_COOL;
            else if (cnt_q == FAN_LAST) state_d = S_G1_UP;
         end
         S_G1_UP: begin
            if (!ps_on)               state_d = S_COOL;
            else if (cnt_q == G1_LAST) state_d = S_CA_WARM;
         end
         S_CA_WARM: begin
            if (!ps_on)               state_d = S_COOL;
            else if (cnt_q == CA_LAST) state_d = S_STANDBY;
         end
         S_STANDBY: begin
            if (!ps_on)      state_d = S_COOL;
            else if (hv_req) state_d = S_G2_UP;
         end
         S_G2_UP: begin
            if (!ps_on)               state_d = S_COOL;
            else if (!hv_req)         state_d = S_STANDBY;
            else if (cnt_q == G2_LAST) state_d = S_AN_WAIT;
         end
         S_AN_WAIT: begin
            if (!hv_rdy && cnt_q == TO_LAST) state_d = S_FAULT;
            else if (!ps_on)                 state_d = S_COOL;
            else if (!hv_req)                state_d = S_STANDBY;
            else if (hv_rdy)                 state_d = S_HV_ON;
         end
         S_HV_ON: begin
            if (!hv_rdy)      state_d = S_FAULT;
            else if (!ps_on)  state_d = S_COOL;
            else if (!hv_req) state_d = S_STANDBY;
         end
         S_COOL: begin
            if (cnt_q == FAN_LAST) state_d = S_OFF;
         end
         S_FAULT: begin
            if (clr && !ps_on) state_d = S_COOL;
         end
         default: state_d = S_OFF;
      endcase
   end

   always_comb begin
      cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
   end

   // Commands are decoded from the next state so they move with the state.
   always_comb begin
      fan_n_d = 1'b1;
      g1_n_d  = 1'b1;
      ca_n_d  = 1'b1;
      g2_n_d  = 1'b1;
      an_n_d  = 1'b1;
      dr_n_d  = 1'b1;
      fault_d = 1'b0;
      unique case (state_d)
         S_OFF: ;
         S_FAN_UP, S_COOL: begin
            fan_n_d = 1'b0;
         end
         S_FAULT: begin
            fan_n_d = 1'b0;
            fault_d = 1'b1;
         end
         S_G1_UP: begin
            fan_n_d = 1'b0;
            g1_n_d  = 1'b0;
         end
         S_CA_WARM, S_STANDBY: begin
            fan_n_d = 1'b0;
            g1_n_d  = 1'b0;
            ca_n_d  = 1'b0;
         end
         S_G2_UP: begin
            fan_n_d = 1'b0;
            g1_n_d  = 1'b0;
            ca_n_d  = 1'b0;
            g2_n_d  = 1'b0;
         end
         S_AN_WAIT, S_HV_ON: begin
            fan_n_d = 1'b0;
            g1_n_d  = 1'b0;
            ca_n_d  = 1'b0;
            g2_n_d  = 1'b0;
            an_n_d  = 1'b0;
            dr_n_d  = ~((state_d == S_HV_ON) && rf_ok);
         end
         default: ;
      endcase
   end

   assign bus.o4_Not_FAN_ON    = fan_n_q;
   assign bus.o5_Not_G1_ON     = g1_n_q;
   assign bus.o6_Not_CA_ON     = ca_n_q;
   assign bus.o18_Not_G2_ON    = g2_n_q;
   assign bus.o19_Not_Anode_ON = an_n_q;
   assign bus.o3_Not_DR_AMP_ON = dr_n_q;
   assign bus.o_FAULT          = fault_q;
   assign bus.o_STATE          = state_q;

endmodule

// File: tb/tb_rpsc_ps_sequencer.sv
// Self-checking bench for rpsc_ps_sequencer: directed scenarios plus a
// randomized run against a dwell-time reference model.
module tb_rpsc_ps_sequencer;

   localparam int FAN = 8;
   localparam int G1  = 4;
   localparam int CA  = 16;
   localparam int G2  = 4;
   localparam int TO  = 32;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   rpsc_ps_sequencer_if bus ();

   rpsc_ps_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: state code plus the edge on which it was entered.
   int cyc     = 0;
   int m_state = 0;
   int m_entry = 0;
   bit m_dr_n  = 1'b1;

   function automatic logic [4:0] en_mask(int s);
      case (s)
         1, 8, 9: return 5'b10000;
         2:       return 5'b11000;
         3, 4:    return 5'b11100;
         5:       return 5'b11110;
         6, 7:    return 5'b11111;
         default: return 5'b00000;
      endcase
   endfunction

   function automatic logic [4:0] obs5();
      return {bus.o4_Not_FAN_ON, bus.o5_Not_G1_ON, bus.o6_Not_CA_ON,
              bus.o18_Not_G2_ON, bus.o19_Not_Anode_ON};
   endfunction

   task automatic step();
      int  held;
      int  ns;
      bit  ps, hv, rdy, clr;
      @(posedge clk);
      cyc++;
      held = cyc - m_entry;
      ps   = bus.i17_PS_ON;
      hv   = bus.i_HV_REQ;
      rdy  = !bus.i73_Not_AN_HV_Ready;
      clr  = bus.i_FAULT_CLR;
      ns   = m_state;
      if (reset) ns = 0;
      else begin
         case (m_state)
            0: if (ps) ns = 1;
            1: if (!ps) ns = 8; else if (held >= FAN) ns = 2;
            2: if (!ps) ns = 8; else if (held >= G1) ns = 3;
            3: if (!ps) ns = 8; else if (held >= CA) ns = 4;
            4: if (!ps) ns = 8; else if (hv) ns = 5;
            5: if (!ps) ns = 8; else if (!hv) ns = 4;
               else if (held >= G2) ns = 6;
            6: if (!rdy && held >= TO) ns = 9; else if (!ps) ns = 8;
               else if (!hv) ns = 4; else if (rdy) ns = 7;
            7: if (!rdy) ns = 9; else if (!ps) ns = 8;
               else if (!hv) ns = 4;
            8: if (held >= FAN) ns = 0;
            9: if (clr && !ps) ns = 8;
            default: ns = 0;
         endcase
      end
      if (reset || ns != m_state) m_entry = cyc;
      m_state = ns;
      m_dr_n  = !(!reset && ns == 7 && !bus.i75_Not_RF_PERM);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if (bus.o_STATE !== 4'd0) begin
         errors++;
         $display("FAIL reset_state got %0d want 0", bus.o_STATE);
      end
      checks++;
      if ({obs5(), bus.o3_Not_DR_AMP_ON} !== 6'h3F) begin
         errors++;
         $display("FAIL reset_outs got %b want 111111",
                  {obs5(), bus.o3_Not_DR_AMP_ON});
      end
      checks++;
      if (bus.o_FAULT !== 1'b0) begin
         errors++;
         $display("FAIL reset_fault got %b want 0", bus.o_FAULT);
      end
      reset = 1'b0;
   endtask

   task automatic test_power_up();
      bit bad = 1'b0;
      bus.i17_PS_ON = 1'b1;
      for (int k = 1; k <= 29; k++) begin
         step();
         if (bus.o18_Not_G2_ON !== 1'b1 || bus.o19_Not_Anode_ON !== 1'b1 ||
             bus.o3_Not_DR_AMP_ON !== 1'b1) bad = 1'b1;
         if (k == 1) begin
            checks++;
            if (bus.o4_Not_FAN_ON !== 1'b0 || bus.o_STATE !== 4'd1) begin
               errors++;
               $display("FAIL pu_fan fan %b st %0d want 0/1",
                        bus.o4_Not_FAN_ON, bus.o_STATE);
            end
         end
         if (k == 8) begin
            checks++;
            if (bus.o5_Not_G1_ON !== 1'b1) begin
               errors++;
               $display("FAIL pu_g1_early got %b want 1", bus.o5_Not_G1_ON);
            end
         end
         if (k == 9) begin
            checks++;
            if (bus.o5_Not_G1_ON !== 1'b0 || bus.o_STATE !== 4'd2) begin
               errors++;
               $display("FAIL pu_g1 g1 %b st %0d want 0/2",
                        bus.o5_Not_G1_ON, bus.o_STATE);
            end
         end
         if (k == 12) begin
            checks++;
            if (bus.o6_Not_CA_ON !== 1'b1) begin
               errors++;
               $display("FAIL pu_ca_early got %b want 1", bus.o6_Not_CA_ON);
            end
         end
         if (k == 13) begin
            checks++;
            if (bus.o6_Not_CA_ON !== 1'b0 || bus.o_STATE !== 4'd3) begin
               errors++;
               $display("FAIL pu_ca ca %b st %0d want 0/3",
                        bus.o6_Not_CA_ON, bus.o_STATE);
            end
         end
         if (k == 28) begin
            checks++;
            if (bus.o_STATE !== 4'd3) begin
               errors++;
               $display("FAIL pu_warm got %0d want 3", bus.o_STATE);
            end
         end
      end
      checks++;
      if (bus.o_STATE !== 4'd4) begin
         errors++;
         $display("FAIL pu_standby got %0d want 4", bus.o_STATE);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL pu_others got low want all 1");
      end
   endtask

   task automatic test_hv_up();
      bus.i75_Not_RF_PERM = 1'b0;
      bus.i_HV_REQ        = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         step();
         if (k == 0) begin
            checks++;
            if (bus.o18_Not_G2_ON !== 1'b0 || bus.o_STATE !== 4'd5) begin
               errors++;
               $display("FAIL hv_g2 g2 %b st %0d want 0/5",
                        bus.o18_Not_G2_ON, bus.o_STATE);
            end
         end
         if (k == 3) begin
            checks++;
            if (bus.o19_Not_Anode_ON !== 1'b1) begin
               errors++;
               $display("FAIL hv_an_early got %b want 1", bus.o19_Not_Anode_ON);
            end
         end
         if (k == 4) begin
            checks++;
            if (bus.o19_Not_Anode_ON !== 1'b0 || bus.o_STATE !== 4'd6) begin
               errors++;
               $display("FAIL hv_an an %b st %0d want 0/6",
                        bus.o19_Not_Anode_ON, bus.o_STATE);
            end
         end
         if (k == 7) begin
            checks++;
            if (bus.o3_Not_DR_AMP_ON !== 1'b1 || bus.o_STATE !== 4'd6) begin
               errors++;
               $display("FAIL hv_wait dr %b st %0d want 1/6",
                        bus.o3_Not_DR_AMP_ON, bus.o_STATE);
            end
            bus.i73_Not_AN_HV_Ready = 1'b0;
         end
      end
      checks++;
      if (bus.o_STATE !== 4'd7 || bus.o3_Not_DR_AMP_ON !== 1'b0) begin
         errors++;
         $display("FAIL hv_on st %0d dr %b want 7/0",
                  bus.o_STATE, bus.o3_Not_DR_AMP_ON);
      end
   endtask

   task automatic test_hv_loss_rf();
      int i;
      bus.i75_Not_RF_PERM = 1'b1;
      #1;
      checks++;
      if (bus.o3_Not_DR_AMP_ON !== 1'b0) begin
         errors++;
         $display("FAIL rf_comb got %b want 0", bus.o3_Not_DR_AMP_ON);
      end
      step();
      checks++;
      if (bus.o3_Not_DR_AMP_ON !== 1'b1) begin
         errors++;
         $display("FAIL rf_off got %b want 1", bus.o3_Not_DR_AMP_ON);
      end
      bus.i75_Not_RF_PERM = 1'b0;
      step();
      checks++;
      if (bus.o3_Not_DR_AMP_ON !== 1'b0) begin
         errors++;
         $display("FAIL rf_on got %b want 0", bus.o3_Not_DR_AMP_ON);
      end
      bus.i_HV_REQ = 1'b0;
      step();
      checks++;
      if (bus.o_STATE !== 4'd4 ||
          {obs5(), bus.o3_Not_DR_AMP_ON} !== 6'b000111) begin
         errors++;
         $display("FAIL hvreq_drop st %0d outs %b want 4/000111",
                  bus.o_STATE, {obs5(), bus.o3_Not_DR_AMP_ON});
      end
      bus.i_HV_REQ = 1'b1;
      for (i = 0; i < 20 && bus.o_STATE !== 4'd7; i++) step();
      checks++;
      if (bus.o_STATE !== 4'd7) begin
         errors++;
         $display("FAIL reach_hv_on st %0d want 7", bus.o_STATE);
      end
      bus.i73_Not_AN_HV_Ready = 1'b1;
      step();
      checks++;
      if (bus.o_STATE !== 4'd9 || bus.o_FAULT !== 1'b1 ||
          obs5() !== 5'b01111) begin
         errors++;
         $display("FAIL hv_loss st %0d flt %b outs %b want 9/1/01111",
                  bus.o_STATE, bus.o_FAULT, obs5());
      end
      bus.i_FAULT_CLR = 1'b1;
      bus.i17_PS_ON   = 1'b0;
      step();
      bus.i_FAULT_CLR = 1'b0;
      checks++;
      if (bus.o_STATE !== 4'd8 || bus.o_FAULT !== 1'b0) begin
         errors++;
         $display("FAIL loss_clr st %0d flt %b want 8/0",
                  bus.o_STATE, bus.o_FAULT);
      end
      for (int k = 1; k <= 8; k++) step();
      checks++;
      if (bus.o_STATE !== 4'd0) begin
         errors++;
         $display("FAIL loss_off st %0d want 0", bus.o_STATE);
      end
   endtask

   task automatic test_timeout();
      int i;
      bus.i17_PS_ON = 1'b1;
      bus.i_HV_REQ  = 1'b1;
      for (i = 0; i < 100 && bus.o_STATE !== 4'd6; i++) step();
      checks++;
      if (bus.o_STATE !== 4'd6) begin
         errors++;
         $display("FAIL reach_an_wait st %0d want 6", bus.o_STATE);
      end
      for (int k = 1; k <= TO; k++) begin
         step();
         if (k == TO - 1) begin
            checks++;
            if (bus.o_STATE !== 4'd6) begin
               errors++;
               $display("FAIL to_early st %0d want 6", bus.o_STATE);
            end
         end
      end
      checks++;
      if (bus.o_STATE !== 4'd9 || bus.o_FAULT !== 1'b1 ||
          {obs5(), bus.o3_Not_DR_AMP_ON} !== 6'b011111) begin
         errors++;
         $display("FAIL to_fault st %0d flt %b outs %b want 9/1/011111",
                  bus.o_STATE, bus.o_FAULT, {obs5(), bus.o3_Not_DR_AMP_ON});
      end
      bus.i_FAULT_CLR = 1'b1;
      step();
      checks++;
      if (bus.o_STATE !== 4'd9 || bus.o_FAULT !== 1'b1) begin
         errors++;
         $display("FAIL clr_ps_on st %0d flt %b want 9/1",
                  bus.o_STATE, bus.o_FAULT);
      end
      bus.i17_PS_ON = 1'b0;
      step();
      bus.i_FAULT_CLR = 1'b0;
      checks++;
      if (bus.o_STATE !== 4'd8 || bus.o_FAULT !== 1'b0) begin
         errors++;
         $display("FAIL clr_cool st %0d flt %b want 8/0",
                  bus.o_STATE, bus.o_FAULT);
      end
      for (int k = 1; k <= FAN; k++) begin
         step();
         if (k == FAN - 1) begin
            checks++;
            if (bus.o_STATE !== 4'd8) begin
               errors++;
               $display("FAIL cool_early st %0d want 8", bus.o_STATE);
            end
         end
      end
      checks++;
      if (bus.o_STATE !== 4'd0 || bus.o4_Not_FAN_ON !== 1'b1) begin
         errors++;
         $display("FAIL cool_off st %0d fan %b want 0/1",
                  bus.o_STATE, bus.o4_Not_FAN_ON);
      end
   endtask

   task automatic test_abort();
      int i;
      bus.i17_PS_ON           = 1'b1;
      bus.i_HV_REQ            = 1'b1;
      bus.i73_Not_AN_HV_Ready = 1'b0;
      for (i = 0; i < 100 && bus.o_STATE !== 4'd7; i++) step();
      checks++;
      if (bus.o_STATE !== 4'd7) begin
         errors++;
         $display("FAIL abort_reach st %0d want 7", bus.o_STATE);
      end
      bus.i17_PS_ON = 1'b0;
      step();
      checks++;
      if (bus.o_STATE !== 4'd8 ||
          {obs5(), bus.o3_Not_DR_AMP_ON} !== 6'b011111) begin
         errors++;
         $display("FAIL abort_cool st %0d outs %b want 8/011111",
                  bus.o_STATE, {obs5(), bus.o3_Not_DR_AMP_ON});
      end
      for (int k = 1; k <= FAN; k++) begin
         if (k == 3) bus.i17_PS_ON = 1'b1;
         step();
         if (k == FAN - 1) begin
            checks++;
            if (bus.o_STATE !== 4'd8) begin
               errors++;
               $display("FAIL abort_hold st %0d want 8", bus.o_STATE);
            end
         end
      end
      checks++;
      if (bus.o_STATE !== 4'd0) begin
         errors++;
         $display("FAIL abort_off st %0d want 0", bus.o_STATE);
      end
      step();
      checks++;
      if (bus.o_STATE !== 4'd1) begin
         errors++;
         $display("FAIL abort_resample st %0d want 1", bus.o_STATE);
      end
   endtask

   task automatic test_reset_mid();
      int i;
      for (i = 0; i < 100 && bus.o_STATE !== 4'd3; i++) step();
      step();
      step();
      checks++;
      if (bus.o_STATE !== 4'd3) begin
         errors++;
         $display("FAIL mid_reach st %0d want 3", bus.o_STATE);
      end
      reset = 1'b1;
      step();
      checks++;
      if (bus.o_STATE !== 4'd0 || bus.o_FAULT !== 1'b0 ||
          {obs5(), bus.o3_Not_DR_AMP_ON} !== 6'h3F) begin
         errors++;
         $display("FAIL mid_reset st %0d flt %b outs %b want 0/0/111111",
                  bus.o_STATE, bus.o_FAULT, {obs5(), bus.o3_Not_DR_AMP_ON});
      end
      reset = 1'b0;
      step();
      checks++;
      if (bus.o_STATE !== 4'd1 || bus.o4_Not_FAN_ON !== 1'b0) begin
         errors++;
         $display("FAIL mid_restart st %0d fan %b want 1/0",
                  bus.o_STATE, bus.o4_Not_FAN_ON);
      end
      for (int k = 1; k <= FAN; k++) begin
         step();
         if (k == FAN - 1) begin
            checks++;
            if (bus.o_STATE !== 4'd1) begin
               errors++;
               $display("FAIL mid_fresh st %0d want 1", bus.o_STATE);
            end
         end
      end
      checks++;
      if (bus.o_STATE !== 4'd2) begin
         errors++;
         $display("FAIL mid_g1 st %0d want 2", bus.o_STATE);
      end
   endtask

   task automatic test_random();
      int rdy_div = 4;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         if (n % 100 == 0) rdy_div = ($urandom_range(0, 1) == 0) ? 4 : 60;
         if ($urandom_range(0, 39) == 0) bus.i17_PS_ON = ~bus.i17_PS_ON;
         if ($urandom_range(0, 19) == 0) bus.i_HV_REQ = ~bus.i_HV_REQ;
         if ($urandom_range(0, rdy_div - 1) == 0)
            bus.i73_Not_AN_HV_Ready = ~bus.i73_Not_AN_HV_Ready;
         bus.i75_Not_RF_PERM = ($urandom_range(0, 3) == 0);
         bus.i_FAULT_CLR     = ($urandom_range(0, 7) == 0);
         reset               = ($urandom_range(0, 499) == 0);
         step();
         checks++;
         if (bus.o_STATE !== 4'(m_state)) begin
            errors++;
            if (errors < 20)
               $display("FAIL rnd_state n %0d got %0d want %0d",
                        n, bus.o_STATE, m_state);
         end
         checks++;
         if (obs5() !== ~en_mask(m_state)) begin
            errors++;
            if (errors < 20)
               $display("FAIL rnd_supplies n %0d got %b want %b",
                        n, obs5(), ~en_mask(m_state));
         end
         checks++;
         if (bus.o_FAULT !== (m_state == 9)) begin
            errors++;
            if (errors < 20)
               $display("FAIL rnd_fault n %0d got %b want %b",
                        n, bus.o_FAULT, (m_state == 9));
         end
         checks++;
         if (bus.o3_Not_DR_AMP_ON !== m_dr_n) begin
            errors++;
            if (errors < 20)
               $display("FAIL rnd_dr n %0d got %b want %b",
                        n, bus.o3_Not_DR_AMP_ON, m_dr_n);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset                   = 1'b1;
      bus.i17_PS_ON           = 1'b0;
      bus.i_HV_REQ            = 1'b0;
      bus.i73_Not_AN_HV_Ready = 1'b1;
      bus.i75_Not_RF_PERM     = 1'b1;
      bus.i_FAULT_CLR         = 1'b0;
      @(negedge clk);
      test_reset();
      test_power_up();
      test_hv_up();
      test_hv_loss_rf();
      test_timeout();
      test_abort();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rpsc_ps_sequencer.md
Name: rpsc_ps_sequencer

Overview:
- Timed power-up/power-down sequencer for the RPSC tube supplies, directly upstream of the standby/HV interlock card.
- Produces the active-low ON commands that the interlock card combines into SB_ON and HV_ON: fan, G1, cathode, G2, anode and driver amp.
- Consumes the anode HV-ready and RF-permit indications passed back from that card.
- Enforces turn-on order and dwell times, and latches a fault on an HV-ready timeout or loss.

Parameters:
- FAN_DLY, 8: cycles in FAN_UP before G1 is enabled; also the COOL dwell.
- G1_DLY, 4: cycles in G1_UP before the cathode is enabled.
- CA_DLY, 16: cathode warm-up cycles before STANDBY.
- G2_DLY, 4: cycles in G2_UP before the anode is enabled.
- HV_TIMEOUT, 32: maximum cycles in AN_WAIT for HV ready.
- CNT_W, 16: dwell counter width. All delays must be at least 1 and at most 2^CNT_W.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i17_PS_ON  in  1  active-high power-supply on request (level)
- i_HV_REQ  in  1  active-high high-voltage request (level)
- i73_Not_AN_HV_Ready  in  1  active-low anode HV ready
- i75_Not_RF_PERM  in  1  active-low RF permit
- i_FAULT_CLR  in  1  active-high fault clear (single-cycle pulse or level)
- o4_Not_FAN_ON  out  1  active-low fan command
- o5_Not_G1_ON  out  1  active-low G1 command
- o6_Not_CA_ON  out  1  active-low cathode command
- o18_Not_G2_ON  out  1  active-low G2 command
- o19_Not_Anode_ON  out  1  active-low anode command
- o3_Not_DR_AMP_ON  out  1  active-low driver amp command
- o_FAULT  out  1  active-high latched fault
- o_STATE  out  4  current state code, for diagnostics

Behaviour:
- Reset is synchronous and active-high and has priority over everything.
  - Reset values: state OFF, counter 0, all Not_* outputs 1 (off), o_FAULT 0, o_STATE 0.
- State codes: OFF=0, FAN_UP=1, G1_UP=2, CA_WARM=3, STANDBY=4, G2_UP=5, AN_WAIT=6, HV_ON=7, COOL=8, FAULT=9.
- All outputs are registered and decoded from the next state, so they change on the same edge the state is entered. There are no combinational input-to-output paths.
- Supplies enabled in each state (asserted = 0):
  - OFF: none
  - FAN_UP, COOL, FAULT: fan only
  - G1_UP: fan, G1
  - CA_WARM, STANDBY: fan, G1, CA
  - G2_UP: fan, G1, CA, G2
  - AN_WAIT, HV_ON: fan, G1, CA, G2, anode
- Driver amp is asserted only in HV_ON with i75_Not_RF_PERM=0. It is registered, so it follows the RF permit with 1 cycle of latency.
- Dwell counter:
  - Clears to 0 on every state entry.
  - In a timed state X, the FSM advances when the counter equals X_DLY-1, so each timed state dwells exactly X_DLY cycles.
- Transition priority, evaluated each cycle: (1) reset, (2) fault conditions, (3) i17_PS_ON=0, (4) i_HV_REQ=0, (5) timed advance.
- Transitions:
  - OFF -> FAN_UP when i17_PS_ON=1.
  - FAN_UP -> G1_UP -> CA_WARM -> STANDBY on dwell expiry.
  - STANDBY -> G2_UP when i_HV_REQ=1.
  - G2_UP -> AN_WAIT on dwell expiry.
  - AN_WAIT -> HV_ON when i73_Not_AN_HV_Ready=0.
  - AN_WAIT -> FAULT when the counter reaches HV_TIMEOUT-1 without HV ready. Ready arriving in that same cycle wins; go to HV_ON.
  - HV_ON -> FAULT if i73_Not_AN_HV_Ready returns to 1.
  - i_HV_REQ=0 in G2_UP, AN_WAIT or HV_ON -> STANDBY. G2, anode and driver amp drop on the same edge.
  - i17_PS_ON=0 in any state from FAN_UP through HV_ON -> COOL (fan only).
  - i17_PS_ON=1 during COOL is ignored. COOL always completes FAN_DLY cycles, then goes to OFF. The request is then re-sampled in OFF.
- FAULT handling:
  - Entering FAULT sets o_FAULT=1, held until the FSM leaves FAULT.
  - Exit is FAULT -> COOL only when i_FAULT_CLR=1 and i17_PS_ON=0 in the same cycle. i_FAULT_CLR has no effect in any other state.
- Anode is never asserted unless G2 has been asserted for at least G2_DLY cycles. G2 is never asserted outside STANDBY-derived states.
- Reset mid-sequence forces all outputs off on that edge with no cool-down.

Test Plan:
- Power-up, default parameters: reset, then i17_PS_ON=1 sampled at edge 1.
  - Required: fan=0 at edge 1; G1=0 at edge 9; CA=0 at edge 13; o_STATE=4 at edge 29. No other Not_* output goes low.
- HV-up: in STANDBY, i_HV_REQ=1 at edge E, HV ready driven 0 at edge E+7, RF permit 0 throughout.
  - Required: G2=0 at E; anode=0 at E+4; HV_ON at E+8; driver amp=0 at E+8, since the permit is already low.
- Timeout: in AN_WAIT, hold i73_Not_AN_HV_Ready=1.
  - Required: exactly 32 cycles after AN_WAIT entry, o_STATE=9 and o_FAULT=1; only fan remains 0.
  - Then: i_FAULT_CLR=1 with i17_PS_ON=1 -> stays in FAULT. i_FAULT_CLR=1 with i17_PS_ON=0 -> COOL, then OFF after 8 cycles, o_FAULT=0.
- Abort: drop i17_PS_ON in HV_ON.
  - Required: next edge G1/CA/G2/anode/driver amp all =1 and fan=0; OFF 8 cycles later. Raising i17_PS_ON during COOL does not shorten the cool-down.
- HV loss and RF gating:
  - In HV_ON, toggle i75_Not_RF_PERM 0/1 -> driver amp follows with 1 cycle of latency.
  - Raise i73_Not_AN_HV_Ready -> FAULT on the next edge.
  - Drop i_HV_REQ in HV_ON -> STANDBY with CA still 0.
- Reset mid-operation: assert reset in CA_WARM.
  - Required: all outputs =1 and o_STATE=0 on that edge.
  - Required: after release with i17_PS_ON=1, the full sequence restarts from FAN_UP with fresh dwell counts.
